// File: rtl/seq_ppg_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_ppg_multiplier
// Purpose  : Sequential unsigned multiplier. Each RUN cycle it generates ROWS
//            AND-style partial-product rows (a & {W{b[i]}}, shifted by i).
//            It adds those rows into a 2W-bit accumulator. In approximate
//            mode, the low TRUNC product columns of every row are zeroed.
// Ports    : clk, rst             - rising-edge clock, sync active-high reset
//            in_valid/in_ready    - operand handshake (ready only in IDLE)
//            a, b, approx_en      - operands and approx select (sampled at accept)
//            out_valid/out_ready  - product handshake
//            product              - 2W-bit result, held while not accepted
//            busy                 - high in RUN or DONE
// Revision : 1.0 - initial release
// ============================================================================
module seq_ppg_multiplier #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 1,
  parameter int TRUNC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int N  = WIDTH / ROWS;
  localparam int CW = $clog2(N) + 1;

  generate
    if (WIDTH % ROWS != 0) begin : g_bad_rows
      $error("seq_ppg_multiplier: ROWS must divide WIDTH");
    end
    if (TRUNC < 0 || TRUNC > PW) begin : g_bad_trunc
      $error("seq_ppg_multiplier: TRUNC must be in 0..2*WIDTH");
    end
  endgenerate

  // Column k survives truncation only if k >= TRUNC. TRUNC == 2W gives an
  // all-zero mask, which avoids the 1<<2W overflow of the naive expression.
  function automatic logic [PW-1:0] trunc_mask(input int t);
    logic [PW-1:0] m;
    for (int k = 0; k < PW; k++) begin
      m[k] = (k >= t);
    end
    return m;
  endfunction

  localparam logic [PW-1:0] TRUNC_MASK = trunc_mask(TRUNC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            approx_reg;
  // The multiplicand is pre-shifted and the multiplier is consumed from the
  // LSB end. Row j of the current group is therefore always (a_sh << j)
  // gated by b_sh[j], and no variable-index shifter is needed.
  logic [PW-1:0]   a_sh;
  logic [WIDTH-1:0] b_sh;

  logic [PW-1:0]   row   [ROWS];
  logic [PW-1:0]   row_sum;

  generate
    for (genvar j = 0; j < ROWS; j++) begin : g_row
      logic [PW-1:0] raw;
      assign raw    = (a_sh << j) & {PW{b_sh[j]}};
      assign row[j] = approx_reg ? (raw & TRUNC_MASK) : raw;
    end
  endgenerate

  always_comb begin
    row_sum = '0;
    for (int j = 0; j < ROWS; j++) begin
      row_sum = row_sum + row[j];
    end
  end

  assign product = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      approx_reg <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh       <= {{WIDTH{1'b0}}, a};
            b_sh       <= b;
            approx_reg <= approx_en;
            acc        <= '0;
            cnt        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + row_sum;
          a_sh <= a_sh << ROWS;
          b_sh <= b_sh >> ROWS;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_ppg_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_ppg_multiplier
// Purpose  : Self-checking bench for seq_ppg_multiplier. It uses two
//            instances, both with WIDTH=16 and TRUNC=8. Instance 0 has
//            ROWS=1 and instance 1 has ROWS=4. The bench applies a
//            directed vector table, hand-written corner sequences, and
//            random operands checked against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ppg_multiplier;

  localparam int W  = 16;
  localparam int TR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0 : ROWS=1
  logic          iv0 = 0, ir0, ap0 = 0, ov0, or0 = 1, bz0;
  logic [W-1:0]  a0 = '0, b0 = '0;
  logic [2*W-1:0] p0;
  // instance 1 : ROWS=4
  logic          iv1 = 0, ir1, ap1 = 0, ov1, or1 = 1, bz1;
  logic [W-1:0]  a1 = '0, b1 = '0;
  logic [2*W-1:0] p1;

  seq_ppg_multiplier #(.WIDTH(W), .ROWS(1), .TRUNC(TR)) dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .approx_en(ap0), .out_valid(ov0), .out_ready(or0), .product(p0), .busy(bz0));

  seq_ppg_multiplier #(.WIDTH(W), .ROWS(4), .TRUNC(TR)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .approx_en(ap1), .out_valid(ov1), .out_ready(or1), .product(p1), .busy(bz1));

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: shift-and-add over the rows, computed with plain integers.
  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input bit ap, input int trunc);
    longint sum = 0;
    longint rowv;
    if (!ap) return x * y;
    for (int i = 0; i < W; i++) begin
      rowv = y[i] ? (longint'(x) << i) : 0;
      if (trunc >= 2 * W) rowv = 0;
      else rowv = rowv & ~((longint'(1) << trunc) - 1);
      sum += rowv;
    end
    return sum[31:0];
  endfunction

  function automatic logic get_ov(input int w);  return (w == 0) ? ov0 : ov1; endfunction
  function automatic logic get_ir(input int w);  return (w == 0) ? ir0 : ir1; endfunction
  function automatic logic get_bz(input int w);  return (w == 0) ? bz0 : bz1; endfunction
  function automatic logic [31:0] get_p(input int w); return (w == 0) ? p0 : p1; endfunction

  task automatic drive(input int w, input logic [15:0] x, input logic [15:0] y,
                       input bit ap, input bit v);
    if (w == 0) begin a0 = x; b0 = y; ap0 = ap; iv0 = v; end
    else        begin a1 = x; b1 = y; ap1 = ap; iv1 = v; end
  endtask

  // Accept one operation and wait for out_valid. If mess is set, the task
  // keeps in_valid high with new operands during RUN. It returns the product
  // and the number of edges from accept to out_valid. The result is consumed
  // with out_ready high, and the DUT is back in IDLE on return.
  task automatic run_op(input int w, input logic [15:0] x, input logic [15:0] y,
                        input bit ap, input bit mess,
                        output logic [31:0] got, output int lat);
    @(negedge clk);
    drive(w, x, y, ap, 1'b1);
    check("in_ready_before_accept", get_ir(w), 1);
    @(posedge clk); #1;
    if (mess) drive(w, 16'hFFFF, 16'hFFFF, ~ap, 1'b1);
    else      drive(w, 16'h0, 16'h0, 1'b0, 1'b0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (get_ov(w)) break;
      if (mess && get_ir(w) !== 1'b0) check("in_ready_low_in_run", get_ir(w), 0);
    end
    drive(w, 16'h0, 16'h0, 1'b0, 1'b0);
    got = get_p(w);
    if (!get_ov(w)) check("out_valid_timeout", 0, 1);
    @(posedge clk); #1;
    check("out_valid_drops", get_ov(w), 0);
  endtask

  typedef struct {
    int          w;
    logic [15:0] x;
    logic [15:0] y;
    bit          ap;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] got;
    int          lat;
    logic [31:0] held;

    tbl[0] = '{0, 16'h0003, 16'h0005, 1'b0, 32'h0000000F};
    tbl[1] = '{0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    tbl[2] = '{1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    tbl[3] = '{0, 16'h00FF, 16'h00FF, 1'b1, 32'h0000F700};
    tbl[4] = '{0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01};
    tbl[5] = '{1, 16'h00FF, 16'h00FF, 1'b1, 32'h0000F700};
    tbl[6] = '{0, 16'h0000, 16'h1234, 1'b1, 32'h00000000};
    tbl[7] = '{1, 16'h1234, 16'h0000, 1'b0, 32'h00000000};
    tbl[8] = '{1, 16'h0007, 16'h0009, 1'b0, 32'h0000003F};
    tbl[9] = '{0, 16'h8000, 16'h8000, 1'b1, 32'h40000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", ov0, 0);
    check("rst_product",   p0,  0);
    check("rst_in_ready",  ir0, 1);
    check("rst_busy",      bz0, 0);
    check("rst_out_valid4", ov1, 0);
    check("rst_in_ready4",  ir1, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].w, tbl[i].x, tbl[i].y, tbl[i].ap, 1'b0, got, lat);
      check($sformatf("table%0d_product", i), got, tbl[i].exp);
      check($sformatf("table%0d_latency", i), lat, (tbl[i].w == 0) ? 16 : 4);
    end

    // Back-pressure: hold product for 10 cycles
    @(negedge clk);
    or0 = 1'b0;
    drive(0, 16'd123, 16'd456, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
    lat = 0;
    while (lat < 40 && !ov0) begin @(posedge clk); #1; lat++; end
    check("bp_latency", lat, 16);
    held = p0;
    check("bp_product", held, 32'd56088);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid_hold", ov0, 1);
      check("bp_product_hold", p0, held);
      check("bp_in_ready_low", ir0, 0);
      check("bp_busy_high", bz0, 1);
    end
    @(negedge clk);
    or0 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", ov0, 0);
    check("bp_release_in_ready", ir0, 1);
    run_op(0, 16'd7, 16'd9, 1'b0, 1'b0, got, lat);
    check("bp_next_product", got, 32'h3F);

    // Reset mid-RUN (counter = 5)
    @(negedge clk);
    drive(0, 16'h00AB, 16'h00CD, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", ov0, 0);
    check("midrst_in_ready", ir0, 1);
    check("midrst_busy", bz0, 0);
    check("midrst_product", p0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov0) check("midrst_stale_out_valid", ov0, 0);
    end
    run_op(0, 16'd2, 16'd2, 1'b0, 1'b0, got, lat);
    check("midrst_next_product", got, 32'd4);

    // Operand change during RUN
    run_op(0, 16'd10, 16'd10, 1'b0, 1'b1, got, lat);
    check("opchg_product", got, 32'd100);
    check("opchg_latency", lat, 16);
    run_op(1, 16'd10, 16'd10, 1'b1, 1'b1, got, lat);
    check("opchg4_product", got, model(16'd10, 16'd10, 1'b1, TR));

    // Random operands against the model, on both instances
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      bit ap;
      int w;
      x  = 16'($urandom);
      y  = 16'($urandom);
      ap = 1'($urandom_range(0, 1));
      w  = i % 2;
      run_op(w, x, y, ap, 1'($urandom_range(0, 1)), got, lat);
      check($sformatf("rand%0d_product", i), got, model(x, y, ap, TR));
      check($sformatf("rand%0d_latency", i), lat, (w == 0) ? 16 : 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
